ap_core_param: RTL
==================

// Module: ap_core_param
// PURPOSE
//  Parametrised associative-processor core: CELL_QUANT rows, each holding three WORD_SIZE columns (A, B, C)
//  per bank, with NUM_BANKS selectable banks. Memory mode gives row-addressed read/write of any column.
//  AP mode runs a bit-serial compare/write sequence across all rows in parallel, computing C = A op B.
//  It is the successor of AP_s, with generic width/depth/banks, a 5-op command set and a readable carry flag.
// PARAMETERS
//  WORD_SIZE   8    bits per column word
//  CELL_QUANT  512  rows per bank; address width AW = clogb2(CELL_QUANT)
//  NUM_BANKS   2    independent banks (was sel_internal_col); BW = max(1,clogb2(NUM_BANKS-1))
// PORTS
//  CLK100MHZ     in   1          single clock, all logic on posedge
//  rst           in   1          synchronous, active-high reset
//  ap_mode       in   1          0 = memory mode; 1 = request AP operation
//  cmd           in   3          AP op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5-7 reserved
//  sel_col       in   2          0 = A, 1 = B, 2 = C, 3 = carry flag (read-only)
//  sel_bank      in   BW         bank for memory access and for AP operation
//  write_en      in   1          memory-mode write strobe
//  read_en       in   1          memory-mode read strobe
//  addr_in       in   AW         row address
//  data_in       in   WORD_SIZE  write data
//  data_out      out  WORD_SIZE  registered read data
//  ap_busy       out  1          high while the sequencer is between start and DONE
//  ap_state_irq  out  1          high in DONE until ap_mode drops
// BEHAVIOUR
//  Reset: FSM=IDLE; data_out=0, ap_busy=0, ap_state_irq=0. All A/B/C/carry/tag storage in every bank is 0.
//   rst wins over every other input, including in the middle of an AP operation (that operation is abandoned).
//  Memory mode (state IDLE, ap_mode=0):
//   write_en=1 -> mem[sel_bank][sel_col][addr_in] <= data_in. Writes with sel_col=3 are ignored.
//   read_en=1 -> data_out = mem[sel_bank][sel_col][addr_in] on the next edge (1-cycle latency).
//    sel_col=3 returns {0, carry[addr_in]}.
//   Read and write to the same address in the same cycle: data_out returns the old value.
//   With read_en=0, data_out holds its value.
//  Outside IDLE: write_en and read_en are ignored and data_out holds.
//  FSM: IDLE -> COMPARE <-> WRITE -> CARRY -> ... -> DONE -> IDLE.
//   IDLE: ap_mode=1 at edge t0 latches cmd and sel_bank and clears that bank's cin/cout/carry columns.
//    It then enters COMPARE at t0+1 with bit i=0, pattern p=0. ap_busy=1 from t0+1.
//   COMPARE (1 cycle): tag[r] = ({cin[r],B[r][i],A[r][i]} == p). For logic ops cin is masked and p is 0..3.
//   WRITE (1 cycle): for every tagged row, C[r][i] <= f(p) and cout[r] <= g(p).
//    ADD: f = a^b^cin, g = maj(a,b,cin).
//    SUB (A-B): f = a^b^cin, g = (~a&b) | (~a&cin) | (b&cin), with cin = borrow.
//    AND/OR/XOR: f = the bitwise op; g = 0.
//    Then p++; when p reaches its last value the next state is CARRY, otherwise COMPARE.
//   CARRY (1 cycle): cin <= cout and carry <= cout for all rows; i++; p=0.
//    When i==WORD_SIZE-1 the next state is DONE, otherwise COMPARE.
//   Pass order: bits LSB -> MSB; p ascending 0..7 (ADD/SUB) or 0..3 (logic).
//   Compares read only A, B and cin, so passes within a bit never interact.
//   Cycles per bit: 17 for ADD/SUB, 9 for logic ops.
//   DONE is entered at t0+1+17*WORD_SIZE (ADD/SUB) or t0+1+9*WORD_SIZE (logic).
//   Reserved cmd: DONE at t0+1 with no storage change.
//   DONE: ap_busy=0, ap_state_irq=1. Stays in DONE while ap_mode=1; ap_mode=0 -> IDLE, irq=0 next cycle.
//  Arithmetic is modulo 2^WORD_SIZE. The final carry/borrow of each row stays readable via sel_col=3.
//  A and B are never modified by AP ops. Other banks are untouched.
//  cmd and sel_bank changes while busy have no effect.
// TESTING
//  1 Reset, write A[0]=10 in bank 0, read A[0] -> data_out=10 one cycle after read_en. Read B[0] -> 0.
//  2 Write A[0]=10 in bank 0 and A[0]=55 in bank 1; read both -> 10 and 55 (banks are isolated).
//  3 A[0]=200, B[0]=100, A[5]=3, B[5]=4; ADD -> irq at t0+137 (W=8). C[0]=44 with carry 1; C[5]=7 with carry 0.
//  4 SUB with A[1]=5, B[1]=9 -> C[1]=252, borrow=1. XOR with A=0xF0, B=0xFF -> C=0x0F; irq at t0+73.
//  5 During ADD, pulse write_en to A[0] -> ignored, A unchanged. Hold ap_mode=1 -> irq stays high.
//    Drop ap_mode -> IDLE and irq=0 the next cycle.
//  6 Assert rst mid-ADD -> the next cycle is IDLE, busy=0, irq=0, all reads return 0. cmd=6 -> DONE at t0+1.

Source files
------------

// File: rtl/ap_core_param.sv
// Parametrised associative-processor core: banked A/B/C word columns with row-addressed
// memory access and a bit-serial compare/write sequencer computing C = A op B on all rows.
module ap_core_param #(
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned CELL_QUANT = 512,
  parameter int unsigned NUM_BANKS  = 2,
  localparam int unsigned AW   = $clog2(CELL_QUANT),
  localparam int unsigned BW   = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst,
  input  logic                 ap_mode,
  input  logic [2:0]           cmd,
  input  logic [1:0]           sel_col,
  input  logic [BW-1:0]        sel_bank,
  input  logic                 write_en,
  input  logic                 read_en,
  input  logic [AW-1:0]        addr_in,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 ap_busy,
  output logic                 ap_state_irq
);

  localparam int unsigned BITW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPARE = 3'd1,
    S_WRITE   = 3'd2,
    S_CARRY   = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [BITW-1:0]        bit_q, bit_d;
  logic [2:0]             pat_q, pat_d;
  logic [2:0]             op_q, op_d;
  logic [BW-1:0]          bank_q, bank_d;
  logic                   busy_q, busy_d;
  logic                   irq_q, irq_d;
  logic [WORD_SIZE-1:0]   dout_q, dout_d;

  logic [NUM_BANKS-1:0][CELL_QUANT-1:0][WORD_SIZE-1:0] mem_a_q, mem_a_d;
  logic [NUM_BANKS-1:0][CELL_QUANT-1:0][WORD_SIZE-1:0] mem_b_q, mem_b_d;
  logic [NUM_BANKS-1:0][CELL_QUANT-1:0][WORD_SIZE-1:0] mem_c_q, mem_c_d;
  // carry doubles as cin: both are loaded from cout in CARRY and cleared together at start
  logic [NUM_BANKS-1:0][CELL_QUANT-1:0]                carry_q, carry_d;
  logic [CELL_QUANT-1:0]                               cout_q, cout_d;
  logic [CELL_QUANT-1:0]                               tag_q, tag_d;

  logic is_logic_c;
  logic pa_c, pb_c, pc_c;
  logic f_bit_c, g_bit_c;
  logic last_pat_c;

  // Truth-table bit written for the current pattern p = {cin, b, a}
  always_comb begin
    is_logic_c = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_XOR);
    pa_c       = pat_q[0];
    pb_c       = pat_q[1];
    pc_c       = pat_q[2] & ~is_logic_c;
    f_bit_c    = 1'b0;
    g_bit_c    = 1'b0;
    case (op_q)
      OP_ADD: begin
        f_bit_c = pa_c ^ pb_c ^ pc_c;
        g_bit_c = (pa_c & pb_c) | (pa_c & pc_c) | (pb_c & pc_c);
      end
      OP_SUB: begin
        f_bit_c = pa_c ^ pb_c ^ pc_c;
        g_bit_c = (~pa_c & pb_c) | (~pa_c & pc_c) | (pb_c & pc_c);
      end
      OP_AND:  f_bit_c = pa_c & pb_c;
      OP_OR:   f_bit_c = pa_c | pb_c;
      OP_XOR:  f_bit_c = pa_c ^ pb_c;
      default: ;
    endcase
    last_pat_c = is_logic_c ? (pat_q == 3'd3) : (pat_q == 3'd7);
  end

  // Next-state, storage and output logic
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    pat_d   = pat_q;
    op_d    = op_q;
    bank_d  = bank_q;
    busy_d  = busy_q;
    irq_d   = irq_q;
    dout_d  = dout_q;
    mem_a_d = mem_a_q;
    mem_b_d = mem_b_q;
    mem_c_d = mem_c_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    tag_d   = tag_q;

    case (state_q)
      S_IDLE: begin
        if (ap_mode) begin
          op_d   = cmd;
          bank_d = sel_bank;
          bit_d  = '0;
          pat_d  = '0;
          if (cmd > OP_XOR) begin
            state_d = S_DONE;
            irq_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            carry_d[sel_bank] = '0;
            cout_d            = '0;
            state_d           = S_COMPARE;
            busy_d            = 1'b1;
          end
        end else begin
          if (read_en) begin
            case (sel_col)
              2'd0:    dout_d = mem_a_q[sel_bank][addr_in];
              2'd1:    dout_d = mem_b_q[sel_bank][addr_in];
              2'd2:    dout_d = mem_c_q[sel_bank][addr_in];
              default: dout_d = WORD_SIZE'(carry_q[sel_bank][addr_in]);
            endcase
          end
          if (write_en) begin
            case (sel_col)
              2'd0:    mem_a_d[sel_bank][addr_in] = data_in;
              2'd1:    mem_b_d[sel_bank][addr_in] = data_in;
              2'd2:    mem_c_d[sel_bank][addr_in] = data_in;
              default: ;
            endcase
          end
        end
      end

      S_COMPARE: begin
        for (int unsigned r = 0; r < CELL_QUANT; r++) begin
          tag_d[AW'(r)] = ({carry_q[bank_q][AW'(r)] & ~is_logic_c,
                            mem_b_q[bank_q][AW'(r)][bit_q],
                            mem_a_q[bank_q][AW'(r)][bit_q]} == pat_q);
        end
        state_d = S_WRITE;
      end

      S_WRITE: begin
        for (int unsigned r = 0; r < CELL_QUANT; r++) begin
          if (tag_q[AW'(r)]) begin
            mem_c_d[bank_q][AW'(r)][bit_q] = f_bit_c;
            cout_d[AW'(r)]                 = g_bit_c;
          end
        end
        pat_d   = pat_q + 3'd1;
        state_d = last_pat_c ? S_CARRY : S_COMPARE;
      end

      S_CARRY: begin
        carry_d[bank_q] = cout_q;
        bit_d           = bit_q + BITW'(1);
        pat_d           = '0;
        if (bit_q == BITW'(WORD_SIZE - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          irq_d   = 1'b1;
        end else begin
          state_d = S_COMPARE;
        end
      end

      S_DONE: begin
        if (!ap_mode) begin
          state_d = S_IDLE;
          irq_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      pat_q   <= '0;
      op_q    <= '0;
      bank_q  <= '0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
      dout_q  <= '0;
      mem_a_q <= '0;
      mem_b_q <= '0;
      mem_c_q <= '0;
      carry_q <= '0;
      cout_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      pat_q   <= pat_d;
      op_q    <= op_d;
      bank_q  <= bank_d;
      busy_q  <= busy_d;
      irq_q   <= irq_d;
      dout_q  <= dout_d;
      mem_a_q <= mem_a_d;
      mem_b_q <= mem_b_d;
      mem_c_q <= mem_c_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      tag_q   <= tag_d;
    end
  end

  assign data_out     = dout_q;
  assign ap_busy      = busy_q;
  assign ap_state_irq = irq_q;

endmodule
